// File: rtl/mem_arb.sv
// Two-port SRAM arbiter: CPU data port (P0) and loader port (P1) share one
// single-ported synchronous SRAM. Grants are combinational from registered
// ownership state and the live requests; the owning port may take up to
// MAX_BURST consecutive grants while the other port waits.
module mem_arb #(
    parameter int AWIDTH    = 12,
    parameter int MAX_BURST = 4
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              P0_REQ,
    input  logic              P0_WE,
    input  logic [3:0]        P0_BE,
    input  logic [AWIDTH-1:0] P0_ADDR,
    input  logic [31:0]       P0_WDATA,
    input  logic              P1_REQ,
    input  logic              P1_WE,
    input  logic [3:0]        P1_BE,
    input  logic [AWIDTH-1:0] P1_ADDR,
    input  logic [31:0]       P1_WDATA,
    output logic              P0_GNT,
    output logic              P1_GNT,
    output logic              P0_RVALID,
    output logic              P1_RVALID,
    output logic [31:0]       P0_RDATA,
    output logic [31:0]       P1_RDATA,
    output logic              MEM_CSN,
    output logic              MEM_WEN,
    output logic [3:0]        MEM_BE,
    output logic [AWIDTH-1:0] MEM_ADDR,
    output logic [31:0]       MEM_DI,
    input  logic [31:0]       MEM_DOUT,
    output logic [31:0]       STALL_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rd_pend0_q, rd_pend0_d;
    logic        rd_pend1_q, rd_pend1_d;
    logic [31:0] stall_q, stall_d;

    logic        gnt0, gnt1;
    logic        burst_full;

    assign burst_full = (cnt_q == MAX_CNT);

    // Grant decision from ownership state and the current requests.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; that is what keeps latches from being inferred.
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        // Grants are forced low while reset is held, even with requests present.
        if (RSTn) begin
            case (state_q)
                IDLE: begin
                    if (P0_REQ && P1_REQ) begin
                        // Tie goes to the port that was not served last.
                        if (last_q) gnt0 = 1'b1;
                        else        gnt1 = 1'b1;
                    end else begin
                        gnt0 = P0_REQ;
                        gnt1 = P1_REQ;
                    end
                end
                OWN0: begin
                    if (P0_REQ && !(P1_REQ && burst_full)) gnt0 = 1'b1;
                    else if (P1_REQ)                       gnt1 = 1'b1;
                end
                OWN1: begin
                    if (P1_REQ && !(P0_REQ && burst_full)) gnt1 = 1'b1;
                    else if (P0_REQ)                       gnt0 = 1'b1;
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    // Next ownership, burst count, read-pending flags and stall counter.
    always_comb begin
        state_d    = IDLE;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rd_pend0_d = gnt0 && !P0_WE;
        rd_pend1_d = gnt1 && !P1_WE;
        stall_d    = stall_q;

        if (gnt0) begin
            state_d = OWN0;
            last_d  = 1'b0;
            if (state_q == OWN0) cnt_d = burst_full ? MAX_CNT : cnt_q + 4'd1;
            else                 cnt_d = 4'd1;
        end else if (gnt1) begin
            state_d = OWN1;
            last_d  = 1'b1;
            if (state_q == OWN1) cnt_d = burst_full ? MAX_CNT : cnt_q + 4'd1;
            else                 cnt_d = 4'd1;
        end

        // Wraps naturally at 32 bits.
        if ((P0_REQ && !gnt0) || (P1_REQ && !gnt1)) stall_d = stall_q + 32'd1;
    end

    // State register; last_q resets to 1 so P0 wins the first tie.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            cnt_q      <= 4'd0;
            rd_pend0_q <= 1'b0;
            rd_pend1_q <= 1'b0;
            stall_q    <= 32'd0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q    <= state_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            rd_pend0_q <= rd_pend0_d;
            rd_pend1_q <= rd_pend1_d;
            stall_q    <= stall_d;
        end
    end

    // Memory side driven by the granted port in the same cycle; idle values otherwise.
    always_comb begin
        MEM_CSN  = 1'b1;
        MEM_WEN  = 1'b1;
        MEM_BE   = 4'h0;
        MEM_ADDR = '0;
        MEM_DI   = 32'h0;
        if (gnt0) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = !P0_WE;
            MEM_BE   = P0_BE;
            MEM_ADDR = P0_ADDR;
            MEM_DI   = P0_WDATA;
        end else if (gnt1) begin
            MEM_CSN  = 1'b0;
            MEM_WEN  = !P1_WE;
            MEM_BE   = P1_BE;
            MEM_ADDR = P1_ADDR;
            MEM_DI   = P1_WDATA;
        end
    end

    assign P0_GNT    = gnt0;
    assign P1_GNT    = gnt1;
    assign P0_RVALID = rd_pend0_q;
    assign P1_RVALID = rd_pend1_q;
    assign P0_RDATA  = rd_pend0_q ? MEM_DOUT : 32'h0;
    assign P1_RDATA  = rd_pend1_q ? MEM_DOUT : 32'h0;
    assign STALL_CNT = stall_q;

endmodule

// File: tb/tb_mem_arb.sv
// Randomized and directed bench for mem_arb. A behavioural SRAM supplies
// MEM_DOUT; a reference model (ownership/run-length arbitration, golden
// memory image, pending-read slots, stall counter) predicts every output.
module tb_mem_arb;

    localparam int AW = 12;
    localparam int MB = 4;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b1;
    logic          P0_REQ, P0_WE, P1_REQ, P1_WE;
    logic [3:0]    P0_BE, P1_BE;
    logic [AW-1:0] P0_ADDR, P1_ADDR;
    logic [31:0]   P0_WDATA, P1_WDATA;
    logic          P0_GNT, P1_GNT, P0_RVALID, P1_RVALID;
    logic [31:0]   P0_RDATA, P1_RDATA;
    logic          MEM_CSN, MEM_WEN;
    logic [3:0]    MEM_BE;
    logic [AW-1:0] MEM_ADDR;
    logic [31:0]   MEM_DI, MEM_DOUT, STALL_CNT;

    mem_arb #(.AWIDTH(AW), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .P0_REQ(P0_REQ), .P0_WE(P0_WE), .P0_BE(P0_BE), .P0_ADDR(P0_ADDR), .P0_WDATA(P0_WDATA),
        .P1_REQ(P1_REQ), .P1_WE(P1_WE), .P1_BE(P1_BE), .P1_ADDR(P1_ADDR), .P1_WDATA(P1_WDATA),
        .P0_GNT(P0_GNT), .P1_GNT(P1_GNT), .P0_RVALID(P0_RVALID), .P1_RVALID(P1_RVALID),
        .P0_RDATA(P0_RDATA), .P1_RDATA(P1_RDATA),
        .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR),
        .MEM_DI(MEM_DI), .MEM_DOUT(MEM_DOUT), .STALL_CNT(STALL_CNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural synchronous SRAM with a preload port for the bench.
    logic [31:0]   sram [0:(1<<AW)-1];
    logic [31:0]   sram_dout = 32'h0;
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = 32'h0;
    assign MEM_DOUT = sram_dout;

    always @(posedge CLK) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_data;
        end else if (!MEM_CSN) begin
            if (!MEM_WEN) begin
                for (int b = 0; b < 4; b++)
                    if (MEM_BE[b]) sram[MEM_ADDR][b*8 +: 8] <= MEM_DI[b*8 +: 8];
            end else begin
                sram_dout <= sram[MEM_ADDR];
            end
        end
    end

    typedef struct {
        logic          req;
        logic          we;
        logic [3:0]    be;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } preq_t;

    preq_t pr [2];

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] gold [0:63];
    int          m_owner;          // -1 when nobody owns the memory
    int          m_last;
    int          m_run;
    logic        m_pend  [2];
    logic [31:0] m_pdata [2];
    logic [31:0] m_stall;

    // Observations from the most recent step.
    int          obs_gnt;
    logic        obs_rv0, obs_wen, obs_csn;
    logic [31:0] obs_rd0, obs_stall;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        P0_REQ = pr[0].req; P0_WE = pr[0].we; P0_BE = pr[0].be;
        P0_ADDR = pr[0].addr; P0_WDATA = pr[0].wdata;
        P1_REQ = pr[1].req; P1_WE = pr[1].we; P1_BE = pr[1].be;
        P1_ADDR = pr[1].addr; P1_WDATA = pr[1].wdata;
    endtask

    task automatic model_reset();
        m_owner = -1; m_last = 1; m_run = 0;
        m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        m_pdata[0] = 32'h0; m_pdata[1] = 32'h0;
        m_stall = 32'h0;
    endtask

    // Which port should win this cycle, by the arbitration rules.
    function automatic int pick(input logic r0, input logic r1);
        if (!r0 && !r1) return -1;
        if (r0 && !r1)  return 0;
        if (r1 && !r0)  return 1;
        if (m_owner < 0) return 1 - m_last;
        if (m_run >= MB) return 1 - m_owner;
        return m_owner;
    endfunction

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic step();
        int g;
        drive();
        @(negedge CLK);
        g = pick(pr[0].req, pr[1].req);

        obs_gnt   = (P0_GNT && P1_GNT) ? 2 : P0_GNT ? 0 : P1_GNT ? 1 : -1;
        obs_rv0   = P0_RVALID;
        obs_rd0   = P0_RDATA;
        obs_wen   = MEM_WEN;
        obs_csn   = MEM_CSN;
        obs_stall = STALL_CNT;

        check("gnt0", P0_GNT, (g == 0));
        check("gnt1", P1_GNT, (g == 1));
        if (g >= 0) begin
            check("mem_csn", MEM_CSN, 0);
            check("mem_wen", MEM_WEN, pr[g].we ? 1'b0 : 1'b1);
            check("mem_be", MEM_BE, pr[g].be);
            check("mem_addr", MEM_ADDR, pr[g].addr);
            check("mem_di", MEM_DI, pr[g].wdata);
        end else begin
            check("idle_csn", MEM_CSN, 1);
            check("idle_wen", MEM_WEN, 1);
            check("idle_be", MEM_BE, 0);
            check("idle_addr", MEM_ADDR, 0);
            check("idle_di", MEM_DI, 0);
        end
        check("rvalid0", P0_RVALID, m_pend[0]);
        check("rvalid1", P1_RVALID, m_pend[1]);
        check("rdata0", P0_RDATA, m_pend[0] ? m_pdata[0] : 32'h0);
        check("rdata1", P1_RDATA, m_pend[1] ? m_pdata[1] : 32'h0);
        check("stall_cnt", STALL_CNT, m_stall);

        if ((pr[0].req && g != 0) || (pr[1].req && g != 1)) m_stall = m_stall + 32'd1;
        m_pend[0] = 1'b0;
        m_pend[1] = 1'b0;
        if (g >= 0) begin
            if (!pr[g].we) begin
                m_pend[g]  = 1'b1;
                m_pdata[g] = gold[pr[g].addr[5:0]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (pr[g].be[b]) gold[pr[g].addr[5:0]][b*8 +: 8] = pr[g].wdata[b*8 +: 8];
            end
            m_run   = (g == m_owner) ? ((m_run < MB) ? m_run + 1 : MB) : 1;
            m_owner = g;
            m_last  = g;
            pr[g].req = 1'b0;
        end else begin
            m_owner = -1;
        end
        @(posedge CLK);
        #1;
    endtask

    // Assert reset (async), check reset values immediately, release after two edges.
    task automatic apply_reset();
        RSTn   = 1'b0;
        P0_REQ = 1'b1;
        P1_REQ = 1'b1;
        #1;
        check("rst_gnt0", P0_GNT, 0);
        check("rst_gnt1", P1_GNT, 0);
        check("rst_csn", MEM_CSN, 1);
        check("rst_wen", MEM_WEN, 1);
        check("rst_rvalid0", P0_RVALID, 0);
        check("rst_rvalid1", P1_RVALID, 0);
        check("rst_stall", STALL_CNT, 0);
        model_reset();
        pr[0].req = 1'b0;
        pr[1].req = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        drive();
        RSTn = 1'b1;
    endtask

    task automatic refill();
        for (int p = 0; p < 2; p++) begin
            if (!pr[p].req && $urandom_range(0, 99) < 55) begin
                pr[p].req   = 1'b1;
                pr[p].we    = 1'($urandom_range(0, 1));
                pr[p].be    = 4'($urandom_range(0, 15));
                pr[p].addr  = AW'($urandom_range(0, 63));
                pr[p].wdata = $urandom;
            end
        end
    endtask

    initial begin
        int          exp_seq [10];
        logic        p1_skip;
        logic        p1_was;
        logic [31:0] s0;
        int          csn_hi;

        exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        for (int p = 0; p < 2; p++)
            pr[p] = '{req: 1'b0, we: 1'b0, be: 4'h0, addr: '0, wdata: 32'h0};
        drive();
        model_reset();
        #2;
        RSTn = 1'b0;

        // Preload the address window used by all stimulus.
        for (int i = 0; i < 64; i++) begin
            pre_we   = 1'b1;
            pre_addr = AW'(i);
            pre_data = (i == 16) ? 32'h0000_0F00 : $urandom;
            gold[i]  = pre_data;
            @(posedge CLK);
            #1;
        end
        pre_we = 1'b0;
        apply_reset();

        // Single read from a preloaded word.
        pr[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 12'h010, wdata: 32'h0};
        step();
        check("sr_gnt", obs_gnt, 0);
        check("sr_stall", obs_stall, 0);
        step();
        check("sr_rvalid", obs_rv0, 1);
        check("sr_rdata", obs_rd0, 32'h0000_0F00);
        check("sr_stall2", obs_stall, 0);

        // Tie right after reset.
        apply_reset();
        pr[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 12'h001, wdata: 32'h0};
        pr[1] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 12'h002, wdata: 32'h0};
        step();
        check("tie_first", obs_gnt, 0);
        step();
        check("tie_second", obs_gnt, 1);
        step();
        check("tie_stall", obs_stall, 1);

        // Burst limit with both ports contending.
        apply_reset();
        p1_skip = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (!pr[0].req) pr[0] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: AW'(40 + c), wdata: 32'(c)};
            if (!pr[1].req && !p1_skip) pr[1] = '{req: 1'b1, we: 1'b1, be: 4'h3, addr: AW'(50 + c), wdata: 32'(100 + c)};
            p1_skip = 1'b0;
            p1_was  = pr[1].req;
            step();
            check($sformatf("burst_c%0d", c), obs_gnt, exp_seq[c]);
            if (p1_was && !pr[1].req) p1_skip = 1'b1;
        end
        pr[0].req = 1'b0;
        pr[1].req = 1'b0;
        step();

        // Write on P1, then read back on P0.
        pr[1] = '{req: 1'b1, we: 1'b1, be: 4'hF, addr: 12'h020, wdata: 32'h0000_0EEC};
        step();
        check("wr_gnt", obs_gnt, 1);
        check("wr_wen", obs_wen, 0);
        pr[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 12'h020, wdata: 32'h0};
        step();
        check("rb_wen", obs_wen, 1);
        step();
        check("rb_rvalid", obs_rv0, 1);
        check("rb_rdata", obs_rd0, 32'h0000_0EEC);

        // Random traffic against the model.
        repeat (3000) begin
            refill();
            step();
        end

        // Async reset between a read grant and its data cycle.
        pr[0].req = 1'b0;
        pr[1].req = 1'b0;
        step();
        step();
        pr[0] = '{req: 1'b1, we: 1'b0, be: 4'hF, addr: 12'h010, wdata: 32'h0};
        drive();
        @(negedge CLK);
        check("mid_gnt", P0_GNT, 1);
        #2;
        apply_reset();
        step();
        check("mid_rvalid", obs_rv0, 0);
        check("mid_stall", obs_stall, 0);

        // Long idle stretch.
        refill();
        pr[0].req = 1'b1; pr[1].req = 1'b1;
        step();
        step();
        step();
        pr[0].req = 1'b0; pr[1].req = 1'b0;
        step();
        s0 = obs_stall;
        csn_hi = 0;
        repeat (100) begin
            step();
            if (obs_csn) csn_hi++;
        end
        check("idle_csn_cycles", csn_hi, 100);
        check("idle_stall", obs_stall, s0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameters (name, default, meaning): AWIDTH, 12, memory address width; MAX_BURST, 4, max consecutive grants to one port while the other waits (range 1..15).
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 P0_REQ, P1_REQ  input  1 each  access request from CPU data port (P0) or loader port (P1).
REQ-005 P0_WE, P1_WE  input  1 each  1 = write, 0 = read.
REQ-006 P0_BE, P1_BE  input  4 each  byte enables, active-high.
REQ-007 P0_ADDR, P1_ADDR  input  AWIDTH each  word address.
REQ-008 P0_WDATA, P1_WDATA  input  32 each  write data.
REQ-009 P0_GNT, P1_GNT  output  1 each  request accepted this cycle.
REQ-010 P0_RVALID, P1_RVALID  output  1 each  read data valid.
REQ-011 P0_RDATA, P1_RDATA  output  32 each  read data.
REQ-012 MEM_CSN, MEM_WEN  output  1 each  SRAM chip select and write enable, active-low.
REQ-013 MEM_BE  output  4  SRAM byte enables.
REQ-014 MEM_ADDR  output  AWIDTH  SRAM address.
REQ-015 MEM_DI  output  32  SRAM write data.
REQ-016 MEM_DOUT  input  32  SRAM read data, valid one cycle after a read is sampled.
REQ-017 STALL_CNT  output  32  count of cycles in which any request was not granted.

Function
REQ-018 Registered state: owner FSM {IDLE, OWN0, OWN1}, last_port (1 bit), burst cnt (4 bits), rd_pend0/rd_pend1, STALL_CNT.
REQ-019 Grant is combinational from registered state and current REQ inputs; at most one GNT high per cycle; GNT never high without its REQ.
REQ-020 IDLE: one requester -> grant it; both -> grant port != last_port.
REQ-021 OWNo (other port x): grant o if REQ_o and not (REQ_x and cnt == MAX_BURST); otherwise grant x if REQ_x; otherwise no grant.
REQ-022 Next state: grant to port g -> OWNg, last_port = g; cnt = min(cnt+1, MAX_BURST) if g equals previous owner, else 1; no grant -> IDLE, last_port and cnt held.
REQ-023 Granted port drives memory in the same cycle: MEM_CSN=0, MEM_WEN=~WE, MEM_BE/ADDR/DI = port BE/ADDR/WDATA.
REQ-024 No grant -> MEM_CSN=1, MEM_WEN=1, MEM_BE=0, MEM_ADDR=0, MEM_DI=0.
REQ-025 Granted read (WE=0) sets rd_pendg for exactly the next cycle; Pg_RVALID = rd_pendg; Pg_RDATA = MEM_DOUT while RVALID, else 0. Latency GNT -> RVALID is 1 cycle.
REQ-026 Writes produce no RVALID; back-to-back reads on alternating ports return data in grant order, one per cycle.
REQ-027 STALL_CNT increments by 1 each cycle in which (P0_REQ and not P0_GNT) or (P1_REQ and not P1_GNT); wraps from 0xFFFFFFFF to 0.
REQ-028 A requester holds REQ/WE/BE/ADDR/WDATA stable until GNT; the arbiter does not check this.

Reset
REQ-029 RSTn low: state IDLE, last_port=1 (P0 wins first tie), cnt=0, rd_pend=0, STALL_CNT=0; all GNT and RVALID 0, MEM_CSN=1, MEM_WEN=1 while low.
REQ-030 Reset asserted with a read in flight: read dropped, no RVALID after release.
REQ-031 First grant possible in the first cycle after RSTn rises.

Verification
REQ-032 Single read: P0 read ADDR=0x010 with preloaded 0x0000_0F00 -> P0_GNT same cycle, P0_RVALID next cycle with RDATA=0x0000_0F00, STALL_CNT=0.
REQ-033 Tie after reset: both REQ in cycle 1 -> P0 granted, P1 granted next cycle, STALL_CNT=1.
REQ-034 Burst limit: P0 REQ held for 10 cycles, P1 REQ from cycle 0 -> grant pattern P0 x4, P1, P0 x4, then P1 when P1 still requesting; MAX_BURST=4.
REQ-035 Write then read: P1 write 0x0000_0EEC to 0x020 with BE=0xF, then P0 read 0x020 -> P0_RDATA=0x0000_0EEC, MEM_WEN=0 only in write cycle.
REQ-036 Async reset mid-read: RSTn low between GNT and RVALID edge -> no RVALID, outputs at reset values immediately, STALL_CNT=0.
REQ-037 Idle: no REQ for 100 cycles -> MEM_CSN=1 throughout, STALL_CNT unchanged.
